// File: rtl/urt_cmd_pkg.sv
// Shared types and constants for the UART command parser.
// crc8_07 is only referenced when URT_CMD_CRC8_EN is defined.
package urt_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYN1,
    CMD,
    CH,
    ITEM,
    DATA,
    CHK,
    OUT
  } state_t;

  localparam logic [2:0] ERR_CMD  = 3'd1;
  localparam logic [2:0] ERR_CH   = 3'd2;
  localparam logic [2:0] ERR_ITEM = 3'd3;
  localparam logic [2:0] ERR_CHK  = 3'd4;
  localparam logic [2:0] ERR_TMO  = 3'd5;

  localparam logic [15:0] DEF_SYN_CODE = 16'hACAC;
  localparam logic [7:0]  DEF_WR_CMD   = 8'h55;
  localparam logic [7:0]  DEF_RD_CMD   = 8'hAA;

  // CRC-8, poly 0x07, MSB-first, one byte per call.
  function automatic logic [7:0] crc8_07(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/urt_byte_fetch.sv
// Pops the rx FIFO at most once every two cycles and presents the
// returned byte as a one-cycle byte_vld strobe.
module urt_byte_fetch (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic       empty,
  input  logic [7:0] rd_dat,
  output logic       rd_en,
  output logic       byte_vld,
  output logic [7:0] byte_dat
);

  logic in_flight;

  // A pop is only issued when no earlier pop is still awaiting its data.
  assign rd_en    = !empty && !stall && !in_flight;
  assign byte_vld = in_flight;
  assign byte_dat = rd_dat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_flight <= 1'b0;
    end else begin
      in_flight <= rd_en;
    end
  end

endmodule

// File: rtl/urt_cmd_parser.sv
// Sync hunt + write/read command packet parser with checksum and timeout.
// Define URT_CMD_CRC8_EN to check a CRC-8 (poly 0x07) instead of the XOR sum.
module urt_cmd_parser
  import urt_cmd_pkg::*;
#(
  parameter int          NUM_CH      = 2,
  parameter int          NUM_ITEM    = 11,
  parameter int          DATA_BYTES  = 4,
  parameter logic [15:0] SYN_CODE    = DEF_SYN_CODE,
  parameter logic [7:0]  WR_CMD      = DEF_WR_CMD,
  parameter logic [7:0]  RD_CMD      = DEF_RD_CMD,
  parameter int          TIMEOUT_CYC = 1_000_000,
  localparam int         CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int         IW = (NUM_ITEM > 1) ? $clog2(NUM_ITEM) : 1,
  localparam int         DW = 8 * DATA_BYTES
) (
  input  logic          clk_100m,
  input  logic          rst_100m,
  output logic          o_urtrx_rd_en,
  input  logic [7:0]    i_urtrx_rd_dat,
  input  logic          i_urtrx_empty,
  output logic          o_cmd_vld,
  input  logic          i_cmd_rdy,
  output logic          o_cmd_wr,
  output logic [CW-1:0] o_cmd_ch,
  output logic [IW-1:0] o_cmd_item,
  output logic [DW-1:0] o_cmd_dat,
  output logic          o_err_pls,
  output logic [2:0]    o_err_code,
  output logic [15:0]   o_err_cnt
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0] SYN_HI = SYN_CODE[15:8];
  localparam logic [7:0] SYN_LO = SYN_CODE[7:0];

  state_t          state;
  logic [TW-1:0]   tmo_cnt;
  logic            byte_vld;
  logic [7:0]      byte_dat;
  logic            wr_q;
  logic [CW-1:0]   ch_q;
  logic [IW-1:0]   item_q;
  logic [DW-1:0]   dat_q;
  logic [2:0]      dcnt;
  logic [7:0]      chk_acc;
  logic            tmo_run;
  logic            tmo_hit;
  logic            err_hit;
  logic [2:0]      err_sel;

  function automatic logic [7:0] chk_step(input logic [7:0] acc, input logic [7:0] b);
`ifdef URT_CMD_CRC8_EN
    return crc8_07(acc, b);
`else
    return acc ^ b;
`endif
  endfunction

  urt_byte_fetch u_fetch (
    .clk      (clk_100m),
    .rst      (rst_100m),
    .stall    (state == OUT),
    .empty    (i_urtrx_empty),
    .rd_dat   (i_urtrx_rd_dat),
    .rd_en    (o_urtrx_rd_en),
    .byte_vld (byte_vld),
    .byte_dat (byte_dat)
  );

  assign tmo_run = (state != IDLE) && (state != OUT);
  assign tmo_hit = tmo_run && (tmo_cnt == TMO_LAST);

  // Error decode; a timeout masks whatever byte arrives in the same cycle.
  always_comb begin
    err_hit = 1'b0;
    err_sel = 3'd0;
    if (tmo_hit) begin
      err_hit = 1'b1;
      err_sel = ERR_TMO;
    end else if (byte_vld) begin
      case (state)
        CMD: if (byte_dat != WR_CMD && byte_dat != RD_CMD) begin
          err_hit = 1'b1;
          err_sel = ERR_CMD;
        end
        CH: if ({24'd0, byte_dat} >= 32'(NUM_CH)) begin
          err_hit = 1'b1;
          err_sel = ERR_CH;
        end
        ITEM: if ({24'd0, byte_dat} >= 32'(NUM_ITEM)) begin
          err_hit = 1'b1;
          err_sel = ERR_ITEM;
        end
        CHK: if (byte_dat != chk_acc) begin
          err_hit = 1'b1;
          err_sel = ERR_CHK;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_100m or posedge rst_100m) begin
    if (rst_100m) begin
      state      <= IDLE;
      tmo_cnt    <= '0;
      wr_q       <= 1'b0;
      ch_q       <= '0;
      item_q     <= '0;
      dat_q      <= '0;
      dcnt       <= 3'd0;
      chk_acc    <= 8'd0;
      o_cmd_vld  <= 1'b0;
      o_cmd_wr   <= 1'b0;
      o_cmd_ch   <= '0;
      o_cmd_item <= '0;
      o_cmd_dat  <= '0;
    end else if (tmo_hit) begin
      state   <= IDLE;
      tmo_cnt <= '0;
    end else begin
      if (byte_vld || !tmo_run) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
      case (state)
        IDLE: if (byte_vld && byte_dat == SYN_HI) state <= SYN1;
        SYN1: if (byte_vld) begin
          if (byte_dat == SYN_LO)      state <= CMD;
          else if (byte_dat == SYN_HI) state <= SYN1;
          else                         state <= IDLE;
        end
        CMD: if (byte_vld) begin
          if (err_hit) begin
            state <= IDLE;
          end else begin
            wr_q    <= (byte_dat == WR_CMD);
            dat_q   <= '0;
            chk_acc <= chk_step(8'd0, byte_dat);
            state   <= CH;
          end
        end
        CH: if (byte_vld) begin
          if (err_hit) begin
            state <= IDLE;
          end else begin
            ch_q    <= byte_dat[CW-1:0];
            chk_acc <= chk_step(chk_acc, byte_dat);
            state   <= ITEM;
          end
        end
        ITEM: if (byte_vld) begin
          if (err_hit) begin
            state <= IDLE;
          end else begin
            item_q  <= byte_dat[IW-1:0];
            chk_acc <= chk_step(chk_acc, byte_dat);
            dcnt    <= 3'd0;
            state   <= wr_q ? DATA : CHK;
          end
        end
        DATA: if (byte_vld) begin
          dat_q   <= (dat_q << 8) | DW'(byte_dat);
          chk_acc <= chk_step(chk_acc, byte_dat);
          if (dcnt == 3'(DATA_BYTES - 1)) state <= CHK;
          else                            dcnt <= dcnt + 3'd1;
        end
        CHK: if (byte_vld) begin
          if (err_hit) begin
            state <= IDLE;
          end else begin
            o_cmd_vld  <= 1'b1;
            o_cmd_wr   <= wr_q;
            o_cmd_ch   <= ch_q;
            o_cmd_item <= item_q;
            o_cmd_dat  <= dat_q;
            state      <= OUT;
          end
        end
        OUT: if (i_cmd_rdy) begin
          o_cmd_vld <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_100m or posedge rst_100m) begin
    if (rst_100m) begin
      o_err_pls  <= 1'b0;
      o_err_code <= 3'd0;
      o_err_cnt  <= 16'd0;
    end else begin
      o_err_pls <= err_hit;
      if (err_hit) begin
        o_err_code <= err_sel;
        if (o_err_cnt != 16'hFFFF) o_err_cnt <= o_err_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_urt_cmd_parser.sv
// Directed bench for urt_cmd_parser: FIFO model, record scoreboard, error monitor.
// TIMEOUT_CYC is shortened to 64 so the timeout case stays quick.
module tb_urt_cmd_parser;
  import urt_cmd_pkg::*;

  localparam int NUM_CH = 2;
  localparam int NUM_ITEM = 11;
  localparam int DATA_BYTES = 4;
  localparam int TIMEOUT_CYC = 64;
  localparam int CW = 1;
  localparam int IW = 4;
  localparam int DW = 32;
  localparam int RW = 1 + CW + IW + DW;

  logic          clk_100m = 1'b0;
  logic          rst_100m = 1'b1;
  logic          o_urtrx_rd_en;
  logic [7:0]    i_urtrx_rd_dat = 8'd0;
  logic          i_urtrx_empty = 1'b1;
  logic          o_cmd_vld;
  logic          i_cmd_rdy = 1'b0;
  logic          o_cmd_wr;
  logic [CW-1:0] o_cmd_ch;
  logic [IW-1:0] o_cmd_item;
  logic [DW-1:0] o_cmd_dat;
  logic          o_err_pls;
  logic [2:0]    o_err_code;
  logic [15:0]   o_err_cnt;

  int checks = 0;
  int failures = 0;

  // clock / reset
  always #5 clk_100m = ~clk_100m;

  urt_cmd_parser #(
    .NUM_CH(NUM_CH), .NUM_ITEM(NUM_ITEM), .DATA_BYTES(DATA_BYTES), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk_100m(clk_100m), .rst_100m(rst_100m),
    .o_urtrx_rd_en(o_urtrx_rd_en), .i_urtrx_rd_dat(i_urtrx_rd_dat), .i_urtrx_empty(i_urtrx_empty),
    .o_cmd_vld(o_cmd_vld), .i_cmd_rdy(i_cmd_rdy), .o_cmd_wr(o_cmd_wr), .o_cmd_ch(o_cmd_ch),
    .o_cmd_item(o_cmd_item), .o_cmd_dat(o_cmd_dat),
    .o_err_pls(o_err_pls), .o_err_code(o_err_code), .o_err_cnt(o_err_cnt)
  );

  // rx FIFO model: data appears the cycle after the pop
  logic [7:0] fifo_q[$];
  always @(posedge clk_100m) begin
    if (o_urtrx_rd_en) begin
      if (fifo_q.size() > 0) i_urtrx_rd_dat <= fifo_q.pop_front();
      else                   i_urtrx_rd_dat <= 8'hEE;
    end
  end
  always @(negedge clk_100m) i_urtrx_empty = (fifo_q.size() == 0);

  // monitor + scoreboard queues
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] got_q[$];
  int cyc = 0, pop_cyc = 0, vld_cyc = 0;
  int err_pulses = 0, pls_double = 0, pop_in_out = 0;
  logic prev_pls = 1'b0, prev_vld = 1'b0;

  always @(negedge clk_100m) begin
    cyc++;
    if (!rst_100m) begin
      if (o_cmd_vld && i_cmd_rdy) got_q.push_back({o_cmd_wr, o_cmd_ch, o_cmd_item, o_cmd_dat});
      if (o_err_pls) err_pulses++;
      if (o_err_pls && prev_pls) pls_double++;
      if (o_cmd_vld && o_urtrx_rd_en) pop_in_out++;
      if (o_urtrx_rd_en) pop_cyc = cyc;
      if (o_cmd_vld && !prev_vld) vld_cyc = cyc;
      prev_pls = o_err_pls;
      prev_vld = o_cmd_vld;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk_100m);
    #2;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] mk_rec(input logic wr, input int ch, input int item,
                                            input logic [DW-1:0] dat);
    return {wr, CW'(ch), IW'(item), dat};
  endfunction

  task automatic raw(input logic [7:0] b);
    fifo_q.push_back(b);
  endtask

  task automatic send_wr(input logic [7:0] ch, input logic [7:0] item,
                         input logic [31:0] dat, input logic [7:0] chk);
    raw(8'hAC); raw(8'hAC); raw(8'h55); raw(ch); raw(item);
    raw(dat[31:24]); raw(dat[23:16]); raw(dat[15:8]); raw(dat[7:0]); raw(chk);
  endtask

  task automatic send_rd(input logic [7:0] ch, input logic [7:0] item, input logic [7:0] chk);
    raw(8'hAC); raw(8'hAC); raw(8'hAA); raw(ch); raw(item); raw(chk);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (fifo_q.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    check({tag, "_drain"}, 64'(n < 500), 64'd1);
    repeat (8) tick();
  endtask

  task automatic score(input string tag, input int n);
    check({tag, "_nrec"}, 64'(got_q.size()), 64'(n));
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_rec"}, 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int n;
    repeat (3) tick();
    check("rst_vld", 64'(o_cmd_vld), 64'd0);
    check("rst_err_cnt", 64'(o_err_cnt), 64'd0);
    check("rst_err_code", 64'(o_err_code), 64'd0);
    check("rst_err_pls", 64'(o_err_pls), 64'd0);
    check("rst_rd_en", 64'(o_urtrx_rd_en), 64'd0);
    check("rst_state", 64'(dut.state), 64'(IDLE));
    rst_100m = 1'b0;
    i_cmd_rdy = 1'b1;
    tick();

    // write packet, checksum 55^01^02^12^34^56^78 = 5E
    exp_q.push_back(mk_rec(1'b1, 1, 2, 32'h12345678));
    send_wr(8'h01, 8'h02, 32'h12345678, 8'h5E);
    wait_drain("wr");
    score("wr", 1);
    check("wr_vld_lat", 64'(vld_cyc - pop_cyc), 64'd2);
    check("wr_err_cnt", 64'(o_err_cnt), 64'd0);

    // read packet, AA^00^03 = A9
    exp_q.push_back(mk_rec(1'b0, 0, 3, 32'd0));
    send_rd(8'h00, 8'h03, 8'hA9);
    wait_drain("rd");
    score("rd", 1);

    // garbage then re-sync: 00 -> IDLE, AC -> SYN1, 11 -> IDLE, then a clean packet
    exp_q.push_back(mk_rec(1'b1, 1, 2, 32'h12345678));
    raw(8'h00); raw(8'hAC); raw(8'h11);
    send_wr(8'h01, 8'h02, 32'h12345678, 8'h5E);
    wait_drain("rehunt");
    score("rehunt", 1);
    check("rehunt_err_cnt", 64'(o_err_cnt), 64'd0);

    // with sync AC AC, the third AC lands in CMD: bad command, tail ignored in IDLE
    raw(8'h00); raw(8'hAC); raw(8'hAC); raw(8'hAC);
    raw(8'h55); raw(8'h01); raw(8'h02); raw(8'h12); raw(8'h34); raw(8'h56); raw(8'h78); raw(8'h5E);
    wait_drain("badcmd");
    score("badcmd", 0);
    check("badcmd_code", 64'(o_err_code), 64'd1);
    check("badcmd_cnt", 64'(o_err_cnt), 64'd1);

    // bad checksum, then a good read packet is still accepted
    send_wr(8'h01, 8'h02, 32'h12345678, 8'h5F);
    wait_drain("badchk");
    score("badchk", 0);
    check("badchk_code", 64'(o_err_code), 64'd4);
    check("badchk_cnt", 64'(o_err_cnt), 64'd2);
    exp_q.push_back(mk_rec(1'b0, 0, 3, 32'd0));
    send_rd(8'h00, 8'h03, 8'hA9);
    wait_drain("after_chk");
    score("after_chk", 1);

    // channel 2 is out of range for NUM_CH = 2
    raw(8'hAC); raw(8'hAC); raw(8'hAA); raw(8'h02);
    wait_drain("badch");
    check("badch_code", 64'(o_err_code), 64'd2);
    check("badch_cnt", 64'(o_err_cnt), 64'd3);

    // item 11 is out of range, item 10 is the last legal one (AA^01^0A = A1)
    raw(8'hAC); raw(8'hAC); raw(8'hAA); raw(8'h00); raw(8'h0B);
    wait_drain("baditem");
    check("baditem_code", 64'(o_err_code), 64'd3);
    check("baditem_cnt", 64'(o_err_cnt), 64'd4);
    exp_q.push_back(mk_rec(1'b0, 1, 10, 32'd0));
    send_rd(8'h01, 8'h0A, 8'hA1);
    wait_drain("item_max");
    score("item_max", 1);

    // stall after the command byte until the inter-byte timeout fires
    raw(8'hAC); raw(8'hAC); raw(8'h55);
    n = 0;
    while (fifo_q.size() != 0 && n < 100) begin tick(); n++; end
    n = 0;
    while (!o_err_pls && n < 300) begin tick(); n++; end
    check("tmo_seen", 64'(o_err_pls), 64'd1);
    check("tmo_window", 64'(n >= 60 && n <= 70), 64'd1);
    check("tmo_code", 64'(o_err_code), 64'd5);
    check("tmo_cnt", 64'(o_err_cnt), 64'd5);
    check("tmo_state", 64'(dut.state), 64'(IDLE));
    repeat (4) tick();

    // back-to-back packets with downstream stalled for 100 cycles
    i_cmd_rdy = 1'b0;
    exp_q.push_back(mk_rec(1'b1, 1, 2, 32'h12345678));
    exp_q.push_back(mk_rec(1'b0, 0, 3, 32'd0));
    send_wr(8'h01, 8'h02, 32'h12345678, 8'h5E);
    send_rd(8'h00, 8'h03, 8'hA9);
    n = 0;
    while (!o_cmd_vld && n < 200) begin tick(); n++; end
    check("stall_vld_seen", 64'(o_cmd_vld), 64'd1);
    repeat (100) tick();
    check("stall_vld_held", 64'(o_cmd_vld), 64'd1);
    check("stall_fields", 64'({o_cmd_wr, o_cmd_ch, o_cmd_item, o_cmd_dat}),
          64'(mk_rec(1'b1, 1, 2, 32'h12345678)));
    check("stall_fifo_left", 64'(fifo_q.size()), 64'd6);
    check("stall_no_pop", 64'(pop_in_out), 64'd0);
    i_cmd_rdy = 1'b1;
    wait_drain("b2b");
    score("b2b", 2);
    check("b2b_err_cnt", 64'(o_err_cnt), 64'd5);

    check("err_pulses", 64'(err_pulses), 64'd5);
    check("err_pls_width", 64'(pls_double), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
